// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into 32-bit words,
// writes them to instruction memory and releases processor reset. Optional: LOADER_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              proc_reset,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_HDR0  = 3'd0,
    S_HDR1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_RUN   = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];
  localparam logic [31:0]       CAPACITY = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0]   WL_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t      state_r;
  logic [15:0] n_r;
  logic [1:0]  byte_idx_r;
  logic [23:0] word_r;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  xor_r;
`endif

  logic            accept_s;
  logic [ADDR_W:0] wl_next_s;
  logic            last_word_s;
  logic            hdr_zero_s;
  logic            hdr_too_big_s;

  assign accept_s      = rx_valid && rx_ready;
  assign wl_next_s     = words_loaded + WL_ONE;
  assign last_word_s   = ({{(31-ADDR_W){1'b0}}, wl_next_s} == {16'd0, n_r});
  assign hdr_zero_s    = ({rx_data, n_r[7:0]} == 16'd0);
  assign hdr_too_big_s = ({8'd0, 8'd0, rx_data, n_r[7:0]} > CAPACITY);

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_HDR0;
      n_r          <= 16'd0;
      byte_idx_r   <= 2'd0;
      word_r       <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
      xor_r        <= 8'd0;
`endif
      rx_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE;
      imem_wdata   <= 32'd0;
      proc_reset   <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= {(ADDR_W+1){1'b0}};
    end else begin
      imem_we <= 1'b0;
      case (state_r)
        S_HDR0: begin
          rx_ready <= 1'b1;
          if (accept_s) begin
            n_r[7:0] <= rx_data;
            state_r  <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (accept_s) begin
            n_r[15:8]  <= rx_data;
            byte_idx_r <= 2'd0;
            if (hdr_zero_s) begin
`ifdef LOADER_CHECKSUM_EN
              state_r    <= S_CHK;
`else
              state_r    <= S_RUN;
              rx_ready   <= 1'b0;
              proc_reset <= 1'b0;
              done       <= 1'b1;
`endif
            end else if (hdr_too_big_s) begin
              state_r  <= S_ERROR;
              rx_ready <= 1'b0;
              err      <= 1'b1;
            end else begin
              state_r <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept_s) begin
            byte_idx_r <= byte_idx_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            xor_r      <= xor_r ^ rx_data;
`endif
            case (byte_idx_r)
              2'd0:    word_r[7:0]   <= rx_data;
              2'd1:    word_r[15:8]  <= rx_data;
              2'd2:    word_r[23:16] <= rx_data;
              default: begin
                // Fourth byte goes straight into the write word; word_r only holds the first three.
                state_r    <= S_WRITE;
                rx_ready   <= 1'b0;
                imem_we    <= 1'b1;
                imem_wdata <= {rx_data, word_r};
                imem_addr  <= BASE + words_loaded[ADDR_W-1:0];
              end
            endcase
          end
        end

        S_WRITE: begin
          words_loaded <= wl_next_s;
          byte_idx_r   <= 2'd0;
          if (last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
            state_r    <= S_CHK;
            rx_ready   <= 1'b1;
`else
            state_r    <= S_RUN;
            proc_reset <= 1'b0;
            done       <= 1'b1;
`endif
          end else begin
            state_r  <= S_DATA;
            rx_ready <= 1'b1;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          rx_ready <= 1'b1;
          if (accept_s) begin
            rx_ready <= 1'b0;
            if (rx_data == xor_r) begin
              state_r    <= S_RUN;
              proc_reset <= 1'b0;
              done       <= 1'b1;
            end else begin
              state_r <= S_ERROR;
              err     <= 1'b1;
            end
          end
        end
`endif

        S_RUN: begin
          rx_ready <= 1'b0;
          if (load_req) begin
            state_r      <= S_HDR0;
            rx_ready     <= 1'b1;
            proc_reset   <= 1'b1;
            done         <= 1'b0;
            words_loaded <= {(ADDR_W+1){1'b0}};
            imem_addr    <= BASE;
            byte_idx_r   <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            xor_r        <= 8'd0;
`endif
          end
        end

        S_ERROR: begin
          rx_ready   <= 1'b0;
          err        <= 1'b1;
          proc_reset <= 1'b1;
          done       <= 1'b0;
        end

        default: begin
          state_r    <= S_ERROR;
          rx_ready   <= 1'b0;
          err        <= 1'b1;
          proc_reset <= 1'b1;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
